// File: rtl/cp0_unit_pkg.sv
// Shared CP0 constants: register indices, field positions,
// exception codes and the exception handler entry point.
package cp0_unit_pkg;

  localparam logic [4:0] IDX_SR    = 5'd12;
  localparam logic [4:0] IDX_CAUSE = 5'd13;
  localparam logic [4:0] IDX_EPC   = 5'd14;
  localparam logic [4:0] IDX_PRID  = 5'd15;

  localparam int SR_IM_LSB     = 10;
  localparam int SR_EXL        = 1;
  localparam int SR_IE         = 0;
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId plus the M-stage
// exception/interrupt flush request.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0001,
  parameter int          IM_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [4:0]      cp0_addr,
  input  logic [31:0]     cp0_wdata,
  output logic [31:0]     cp0_rdata,
  input  logic [31:0]     vpc,
  input  logic            bd_in,
  input  logic [4:0]      exc_code_in,
  input  logic            eret,
  input  logic [IM_W-1:0] hw_int,
  output logic            req,
  output logic [31:0]     epc_out
);

  logic [IM_W-1:0] im;
  logic            exl;
  logic            ie;
  logic            bd;
  logic [IM_W-1:0] ip;
  logic [4:0]      exc_code;
  logic [31:0]     epc;

  logic int_req;
  logic exc_req;
  logic wr_sr;
  logic wr_epc;

  assign int_req = ie & ~exl & (|(hw_int & im));
  assign exc_req = ~exl & (|exc_code_in);
  assign req     = ~reset & (int_req | exc_req);

  assign wr_sr  = en & (cp0_addr == IDX_SR);
  assign wr_epc = en & (cp0_addr == IDX_EPC);

  assign epc_out = (wr_epc && !req) ? cp0_wdata : epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl      <= 1'b1;
        bd       <= bd_in;
        exc_code <= int_req ? EXC_INT : exc_code_in;
        epc      <= bd_in ? vpc - 32'd4 : vpc;
      end else begin
        if (wr_sr) begin
          im  <= cp0_wdata[SR_IM_LSB +: IM_W];
          exl <= cp0_wdata[SR_EXL];
          ie  <= cp0_wdata[SR_IE];
        end
        if (wr_epc)
          epc <= cp0_wdata;
        // eret clears EXL after any same-cycle SR write
        if (eret)
          exl <= 1'b0;
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      IDX_SR: begin
        cp0_rdata[SR_IM_LSB +: IM_W] = im;
        cp0_rdata[SR_EXL]            = exl;
        cp0_rdata[SR_IE]             = ie;
      end
      IDX_CAUSE: begin
        cp0_rdata[CAUSE_BD]                = bd;
        cp0_rdata[CAUSE_IP_LSB +: IM_W]    = ip;
        cp0_rdata[CAUSE_EXC_LSB +: 5]      = exc_code;
      end
      IDX_EPC:  cp0_rdata = epc;
      IDX_PRID: cp0_rdata = PRID;
      default:  cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Randomised check of cp0_unit against a word-level CP0 model,
// with directed scenarios pinned by literal expectations.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [31:0] cp0_wdata = '0;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc = '0;
  logic        bd_in = 1'b0;
  logic [4:0]  exc_code_in = '0;
  logic        eret = 1'b0;
  logic [5:0]  hw_int = '0;
  logic        req;
  logic [31:0] epc_out;

  int checks = 0;
  int errors = 0;

  cp0_unit #(.PRID(32'h0000_0001), .IM_W(6)) dut (
    .clk(clk), .reset(reset), .en(en),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .vpc(vpc), .bd_in(bd_in),
    .exc_code_in(exc_code_in), .eret(eret),
    .hw_int(hw_int), .req(req), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h",
               name, act, exp);
    end
  endtask

  // model state as whole architectural words
  logic [31:0] m_sr = '0;
  logic [31:0] m_cause = '0;
  logic [31:0] m_epc = '0;

  initial begin : model
    logic        e_int, e_exc, e_req;
    logic [31:0] e_rd, e_eo;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_int = m_sr[0] && !m_sr[1]
              && ((hw_int & m_sr[15:10]) != 0);
      e_exc = !m_sr[1] && (exc_code_in != 0);
      e_req = !reset && (e_int || e_exc);
      case (cp0_addr)
        5'd12:   e_rd = m_sr;
        5'd13:   e_rd = m_cause;
        5'd14:   e_rd = m_epc;
        5'd15:   e_rd = 32'h0000_0001;
        default: e_rd = 32'h0;
      endcase
      e_eo = (en && cp0_addr == 14 && !e_req)
             ? cp0_wdata : m_epc;
      chk("req", {31'b0, req}, {31'b0, e_req});
      chk("rdata", cp0_rdata, e_rd);
      chk("epc_out", epc_out, e_eo);
      if (reset) begin
        m_sr = 0; m_cause = 0; m_epc = 0;
      end else begin
        m_cause = (m_cause & ~32'h0000_FC00)
                  | ({26'b0, hw_int} << 10);
        if (e_req) begin
          m_sr = m_sr | 32'h2;
          m_cause = (m_cause & 32'h0000_FC00)
                    | ({31'b0, bd_in} << 31)
                    | (e_int ? 32'h0
                       : {27'b0, exc_code_in} << 2);
          m_epc = bd_in ? vpc - 4 : vpc;
        end else begin
          if (en && cp0_addr == 12)
            m_sr = cp0_wdata & 32'h0000_FC03;
          if (en && cp0_addr == 14)
            m_epc = cp0_wdata;
          if (eret)
            m_sr = m_sr & ~32'h2;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(logic [4:0] a);
    reset = 0; en = 0; cp0_addr = a; cp0_wdata = 0;
    vpc = 0; bd_in = 0; exc_code_in = 0; eret = 0;
    hw_int = 0;
  endtask

  task automatic rd(logic [4:0] a, logic [31:0] exp,
                    string name);
    tick; idle(a); #1;
    chk(name, cp0_rdata, exp);
  endtask

  initial begin
    // 1: reset holds req low even with a pending fault
    exc_code_in = 5'd4;
    tick; #1; chk("req_in_reset", {31'b0, req}, 0);
    tick; #1; chk("req_in_reset2", {31'b0, req}, 0);
    rd(5'd12, 32'h0, "sr_reset");
    rd(5'd13, 32'h0, "cause_reset");
    rd(5'd14, 32'h0, "epc_reset");
    rd(5'd15, 32'h1, "prid");
    // 2: RI exception outside a delay slot
    tick; idle(5'd0); exc_code_in = 5'd10;
    vpc = 32'h3010; #1;
    chk("ri_req", {31'b0, req}, 1);
    rd(5'd14, 32'h3010, "ri_epc");
    rd(5'd13, 32'h0000_0028, "ri_cause");
    rd(5'd12, 32'h2, "ri_sr");
    tick; idle(5'd0); exc_code_in = 5'd5; #1;
    chk("nested_req", {31'b0, req}, 0);
    tick; idle(5'd0); eret = 1;
    // 3: interrupt beats a same-cycle overflow
    tick; idle(5'd12); en = 1; cp0_wdata = 32'h401;
    tick; idle(5'd0); hw_int = 6'b1; exc_code_in = 5'd12;
    bd_in = 1; vpc = 32'h3024; #1;
    chk("int_req", {31'b0, req}, 1);
    tick; idle(5'd13); hw_int = 6'b1; #1;
    chk("int_cause", cp0_rdata, 32'h8000_0400);
    rd(5'd14, 32'h3020, "int_epc");
    // 4: mtc0 EPC forwarded to a same-cycle eret
    tick; idle(5'd14); en = 1; cp0_wdata = 32'h3100;
    eret = 1; #1;
    chk("fwd_epc", epc_out, 32'h3100);
    rd(5'd12, 32'h401, "eret_sr");
    rd(5'd14, 32'h3100, "eret_epc");
    // 5: request overrides mtc0 and eret
    tick; idle(5'd14); en = 1; cp0_wdata = 32'hDEAD_BEEF;
    eret = 1; exc_code_in = 5'd4; vpc = 32'h5008; #1;
    chk("ovr_req", {31'b0, req}, 1);
    chk("ovr_epc_out", epc_out, 32'h3100);
    rd(5'd14, 32'h5008, "ovr_epc");
    rd(5'd12, 32'h403, "ovr_sr");
    // 6: write masks and read-only registers
    tick; idle(5'd12); en = 1; cp0_wdata = 32'hFFFF_FFFF;
    rd(5'd12, 32'h0000_FC03, "sr_mask");
    tick; idle(5'd13); en = 1; cp0_wdata = 32'hFFFF_FFFF;
    rd(5'd13, 32'h10, "cause_ro");
    tick; idle(5'd15); en = 1; cp0_wdata = 32'hFFFF_FFFF;
    rd(5'd15, 32'h1, "prid_ro");
    rd(5'd16, 32'h0, "unmapped");
    // wrap of vpc-4 in a delay slot
    tick; idle(5'd0); eret = 1;
    tick; idle(5'd0); exc_code_in = 5'd10; bd_in = 1;
    vpc = 32'h2;
    rd(5'd14, 32'hFFFF_FFFE, "epc_wrap");
    // randomised traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      tick;
      reset = ($urandom_range(99) < 2);
      en = ($urandom_range(99) < 35);
      cp0_addr = ($urandom_range(9) < 8)
                 ? 5'(11 + $urandom_range(4))
                 : 5'($urandom);
      cp0_wdata = $urandom;
      vpc = $urandom;
      bd_in = $urandom_range(1);
      exc_code_in = ($urandom_range(99) < 20)
                    ? 5'($urandom) : 5'd0;
      eret = ($urandom_range(99) < 20);
      hw_int = ($urandom_range(99) < 30)
               ? 6'($urandom) : 6'd0;
    end
    tick; idle(5'd0);
    tick;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
